// File: rtl/surf_jtag_pkg.sv
// Shared types and constants for the JTAG master engine.
// Imported by the divider and the top-level shift engine.
package surf_jtag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    RESP
  } state_t;

  localparam int MAXBITS    = 32;
  localparam int CLKDIV_DEF = 4;

endpackage

// File: rtl/surf_jtag_tck_div.sv
// MTCK half-period counter: reload on phase entry, strobe
// done in the last clk cycle of the phase.
module surf_jtag_tck_div
  import surf_jtag_pkg::*;
#(
  parameter int CLKDIV = CLKDIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= 8'(CLKDIV - 1);
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign done = (cnt == 8'd0);

endmodule

// File: rtl/surf_jtag_master.sv
// JTAG shift engine: serialises TMS/TDI vectors LSB first,
// captures TDO on each MTCK rising edge.
module surf_jtag_master #(
  parameter int CLKDIV  = surf_jtag_pkg::CLKDIV_DEF,
  parameter int MAXBITS = surf_jtag_pkg::MAXBITS
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [4:0]  cmd_nbits_i,
  input  logic [31:0] cmd_tms_i,
  input  logic [31:0] cmd_tdi_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_tdo_o,
  output logic        MTCK,
  output logic        MTMS,
  output logic        MTDI,
  input  logic        MTDO,
  output logic        MSEL
);

  import surf_jtag_pkg::*;

  state_t      state;
  logic [5:0]  nbits;
  logic [4:0]  idx;
  logic [5:0]  nxt;
  logic [5:0]  nbits_eff;
  logic [31:0] tms_r;
  logic [31:0] tdi_r;
  logic        accept;
  logic        load;
  logic        done;

  assign accept    = cmd_valid_i & cmd_ready_o;
  assign nxt       = {1'b0, idx} + 6'd1;
  // A zero count encodes a full-width command
  assign nbits_eff = (cmd_nbits_i == 5'd0) ? 6'(MAXBITS)
                                           : {1'b0, cmd_nbits_i};
  assign load      = accept |
                     (((state == LOW) | (state == HIGH)) & done);

  surf_jtag_tck_div #(
    .CLKDIV (CLKDIV)
  ) u_div (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .load  (load),
    .done  (done)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_tdo_o   <= '0;
      MTCK        <= 1'b0;
      MTMS        <= 1'b1;
      MTDI        <= 1'b0;
      MSEL        <= 1'b0;
      nbits       <= '0;
      idx         <= '0;
      tms_r       <= '0;
      tdi_r       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            nbits       <= nbits_eff;
            tms_r       <= cmd_tms_i;
            tdi_r       <= cmd_tdi_i;
            rsp_tdo_o   <= '0;
            idx         <= '0;
            MTCK        <= 1'b0;
            MTMS        <= cmd_tms_i[0];
            MTDI        <= cmd_tdi_i[0];
            MSEL        <= 1'b1;
            cmd_ready_o <= 1'b0;
            state       <= LOW;
          end
        end
        LOW: begin
          if (done) begin
            MTCK           <= 1'b1;
            rsp_tdo_o[idx] <= MTDO;
            state          <= HIGH;
          end
        end
        HIGH: begin
          if (done) begin
            MTCK <= 1'b0;
            if (nxt < nbits) begin
              idx   <= nxt[4:0];
              MTMS  <= tms_r[nxt[4:0]];
              MTDI  <= tdi_r[nxt[4:0]];
              state <= LOW;
            end else begin
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            MSEL        <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/surf_jtag_master.md
SURF_JTAG_MASTER -- requirements
Module: surf_jtag_master

Interface
REQ-001 SHALL have parameter CLKDIV, default 4: clk_i cycles per MTCK half-period, legal range 1..255.
REQ-002 SHALL have parameter MAXBITS, default 32: maximum bits per command.
REQ-003 SHALL have port clk_i, input, 1: sole clock; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n_i, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid_i, input, 1: command present.
REQ-006 SHALL have port cmd_ready_o, output, 1: engine can accept a command.
REQ-007 SHALL have port cmd_nbits_i, input, 5: bit count; 0 means 32.
REQ-008 SHALL have port cmd_tms_i, input, 32: TMS vector, LSB shifted first.
REQ-009 SHALL have port cmd_tdi_i, input, 32: TDI vector, LSB shifted first.
REQ-010 SHALL have port rsp_valid_o, output, 1: capture result present.
REQ-011 SHALL have port rsp_ready_i, input, 1: consumer accepts result.
REQ-012 SHALL have port rsp_tdo_o, output, 32: captured TDO; bit i is the i-th shifted bit.
REQ-013 SHALL have port MTCK, output, 1: JTAG clock to target.
REQ-014 SHALL have port MTMS, output, 1: JTAG mode select to target.
REQ-015 SHALL have port MTDI, output, 1: JTAG data to target.
REQ-016 SHALL have port MTDO, input, 1: JTAG data from target.
REQ-017 SHALL have port MSEL, output, 1: route target TAP to this master; high from command accept until response handshake completes.

Function
REQ-018 SHALL implement states IDLE, LOW, HIGH, RESP.
REQ-019 SHALL assert cmd_ready_o only in IDLE; a command is accepted on a clk_i edge with cmd_valid_i and cmd_ready_o both high.
REQ-020 SHALL, on accept, latch nbits/tms/tdi, clear the capture register, and enter LOW on the next cycle.
REQ-021 SHALL, on entering LOW for bit i, drive MTCK=0, MTMS=tms[i], MTDI=tdi[i], all registered, and hold them for CLKDIV cycles.
REQ-022 SHALL, on the LOW->HIGH edge, drive MTCK=1 and sample MTDO into capture bit i on that same clk_i edge.
REQ-023 SHALL hold HIGH for CLKDIV cycles, then enter LOW for bit i+1 if i+1<nbits, else enter RESP with MTCK=0.
REQ-024 SHALL make one bit take exactly 2*CLKDIV clk_i cycles, so a command spans accept + 2*CLKDIV*nbits cycles to rsp_valid_o.
REQ-025 SHALL, in RESP, assert rsp_valid_o with stable rsp_tdo_o until rsp_ready_i, then return to IDLE on the next cycle.
REQ-026 SHALL force capture bits >= nbits to zero.
REQ-027 SHALL keep MTMS/MTDI at their last driven values in IDLE and RESP, so the TAP state is preserved between commands.
REQ-028 SHALL ignore cmd_valid_i outside IDLE, including when it is asserted in the same cycle as the rsp handshake.
REQ-029 SHALL treat nbits=0 as 32 with no wrap-around.

Reset
REQ-030 SHALL, on rst_n_i low at any time including mid-shift, immediately enter IDLE and discard partial capture.
REQ-031 SHALL drive the following reset values: MTCK=0, MTMS=1, MTDI=0, MSEL=0, cmd_ready_o=1 after release, rsp_valid_o=0, rsp_tdo_o=0.

Structure
REQ-032 SHALL place the state enum, the MAXBITS constant and the CLKDIV default in shared package surf_jtag_pkg.
REQ-033 SHALL use one sub-module, surf_jtag_tck_div, as the half-period counter issuing a phase-end strobe, reloaded at each state entry.

Verification
REQ-034 SHALL cover TAP reset: nbits=5, tms=0x1F, tdi=0, CLKDIV=4 -> 5 MTCK pulses, MTMS high throughout, rsp_valid_o 40 cycles after accept, rsp_tdo_o from 5 captured bits.
REQ-035 SHALL cover loopback with MTDO tied to MTDI: nbits=0, tdi=0xA5C3_0F81, tms=0 -> 32 pulses, rsp_tdo_o=0xA5C3_0F81.
REQ-036 SHALL cover a partial width: nbits=8, tdi=0xFFFF_FFFF, loopback -> rsp_tdo_o=0x0000_00FF.
REQ-037 SHALL cover backpressure: rsp_ready_i low for 20 cycles -> rsp_valid_o and rsp_tdo_o stable, cmd_ready_o low, MSEL high, then IDLE one cycle after handshake.
REQ-038 SHALL cover mid-shift reset: rst_n_i low after bit 3 of a 16-bit command -> MTCK=0, MTMS=1 asynchronously; after release a new 4-bit loopback command with tdi=0x9 returns 0x9.
REQ-039 SHALL cover minimum divider: CLKDIV=1, nbits=4 -> MTCK toggles every cycle, rsp_valid_o 8 cycles after accept.
